fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the combinational instruction memory: owns the PC, presents it to the ROM and registers each returned word into a one-entry output buffer.
- Buffer drives the decode/execute stage over a valid/ready handshake.
- Provides start, branch redirect, end-of-program detection and a completion pulse.
- Sits between the top-level control/testbench and the decode stage of the TinyML RISC core.

Parameters:
- PROG_WORDS, 16, program window size in 32-bit words; PC at or beyond PROG_WORDS*4 ends the program.
- HALT_ON_ZERO, 1, when 1 a fetched word of 32'h0000_0000 ends the program; that word is not issued.
- CNT_W, 16, width of fetch_count.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin fetching at start_pc; honoured only in IDLE
- start_pc  in  32  first fetch address; bits [1:0] forced to 0
- redirect_valid  in  1  branch redirect; honoured in RUN and DRAIN
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
- imem_pc  out  32  address to instruction memory
- imem_instr  in  32  instruction word returned combinationally for imem_pc
- out_valid  out  1  output buffer holds an instruction
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_instr  out  32  buffered instruction
- out_pc  out  32  address of out_instr
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at program completion
- fetch_count  out  CNT_W  instructions accepted by consumer since last start; saturates at all-ones

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE.
  - pc, out_instr, out_pc and fetch_count = 0.
  - out_valid=0, done=0.
  - rst wins over every other input, including mid-program; the buffer is discarded.
- imem_pc = pc at all times; the ROM is combinational, so fetch and capture happen in the same cycle.
- States:
  - IDLE:
    - start=1: pc<=start_pc, fetch_count<=0, go RUN.
    - All other inputs ignored.
  - RUN:
    - Buffer can load when out_valid=0 or (out_valid & out_ready).
    - End condition: pc >= PROG_WORDS*4, or (HALT_ON_ZERO & imem_instr==0).
    - If the buffer can load and the end condition holds: no capture, go DRAIN.
    - Otherwise, if the buffer can load: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4.
    - If the buffer cannot load: stall; pc and buffer hold.
  - DRAIN:
    - Wait until the buffer empties (out_valid=0 after a handshake), then go DONE.
  - DONE:
    - done=1 for exactly one cycle, then IDLE.
    - A start in DONE is ignored.
- Latency:
  - start seen at edge N -> out_valid=1 with start_pc's word after edge N+1.
  - With out_ready held high, one instruction issues per cycle.
- Redirect (RUN or DRAIN), highest priority after rst:
  - pc<=redirect_pc and state<=RUN.
  - out_valid<=0; a handshake in that same cycle still completes and is counted.
  - No capture in the redirect cycle; first redirected word is valid one cycle later.
  - Ignored in IDLE and DONE.
- fetch_count increments on each handshake and saturates at 2^CNT_W-1.
- pc+4 wraps modulo 2^32; the PROG_WORDS bound ends the program before any wrap.
- out_instr and out_pc are stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package tinyml_isa_pkg:
  - Opcode constants (ADD 0, SUB 1, AND 2, OR 3, XOR 4, LOADI 5, LOADHI 6, MAC4 8).
  - Field positions: opcode [31:28], rd [27:24], rs1 [23:20], rs2 [19:16], imm [15:0].
  - Fetch state encoding and INSTR_BYTES=4.
- No sub-module: the FSM and one-entry buffer fit in a single module.

Test Plan:
- Normal run with the standard program (words 0-6, zero at word 7), start_pc=0, out_ready=1:
  - Outputs in order: 0x5100_0201 @0x00, 0x6110_0403 @0x04, 0x5200_0605 @0x08, 0x6220_0807 @0x0C, 0x8312_0000 @0x10, 0x0430_0000 @0x14, 0x4512_0000 @0x18.
  - done pulses 2 cycles after the last handshake; fetch_count=7; busy=0.
- Backpressure, out_ready=0 for 5 cycles after the first word:
  - out_instr holds 0x5100_0201 with out_valid=1; imem_pc holds 0x04.
  - Resume yields the same 7-word sequence with no loss or duplication.
- Redirect to 0x10 while out_valid=1 at 0x08 and out_ready=0:
  - The 0x08 word is dropped.
  - Next outputs are 0x8312_0000 @0x10, then 0x14 and 0x18; fetch_count=5.
- Reset mid-run (rst=1 at cycle 3 of RUN):
  - Next cycle: out_valid=0, imem_pc=0, fetch_count=0, busy=0, no done pulse.
- start_pc=0x1A:
  - Fetch begins at 0x18 and issues 0x4512_0000 only; done pulses; fetch_count=1.
- start asserted while busy:
  - Ignored; the sequence and count are unchanged from the normal run.

Source files
------------

// File: rtl/tinyml_isa_pkg.sv
// Shared TinyML ISA definitions: opcode values, instruction field positions
// and the fetch sequencer state encoding.
package tinyml_isa_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_LOADI  = 4'h5;
  localparam logic [3:0] OP_LOADHI = 4'h6;
  localparam logic [3:0] OP_MAC4   = 4'h8;

  // Field positions (msb/lsb)
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 24;
  localparam int RS1_MSB = 23;
  localparam int RS1_LSB = 20;
  localparam int RS2_MSB = 19;
  localparam int RS2_LSB = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_DRAIN = 2'd2,
    FS_DONE  = 2'd3
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, reads the combinational instruction ROM and
// registers each word into a one-entry buffer handed to decode over
// valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, start_pc     begin fetching (IDLE only)
//   redirect_valid/_pc  branch redirect (RUN/DRAIN only)
//   imem_pc/imem_instr  ROM address out / word back (same cycle)
//   out_valid/ready     buffer handshake; out_instr/out_pc buffer contents
//   busy, done          activity flag / one-cycle completion pulse
//   fetch_count         saturating count of accepted instructions
module fetch_sequencer
  import tinyml_isa_pkg::*;
#(
  parameter int PROG_WORDS   = 16,
  parameter bit HALT_ON_ZERO = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      start_pc,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] PC_END = 32'(PROG_WORDS * INSTR_BYTES);
  localparam logic [31:0] PC_INC = 32'(INSTR_BYTES);

  fetch_state_e     state_q;
  logic [31:0]      pc_q, instr_q, opc_q;
  logic             vld_q, done_q;
  logic [CNT_W-1:0] cnt_q;

  logic hs, can_load, end_hit;

  assign hs       = vld_q & out_ready;
  assign can_load = ~vld_q | out_ready;
  // The ROM answers in the same cycle, so the end check can look at the word
  // at pc before deciding whether to capture it.
  assign end_hit  = (pc_q >= PC_END) | (HALT_ON_ZERO & (imem_instr == 32'h0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      opc_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (hs && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
      if (hs) vld_q <= 1'b0;
      case (state_q)
        FS_IDLE: begin
          if (start) begin
            pc_q    <= start_pc & ~32'h3;
            cnt_q   <= '0;
            state_q <= FS_RUN;
          end
        end
        FS_RUN, FS_DRAIN: begin
          if (redirect_valid) begin
            // Buffered word is wrong-path; a handshake this cycle still counts.
            pc_q    <= redirect_pc & ~32'h3;
            vld_q   <= 1'b0;
            state_q <= FS_RUN;
          end else if (state_q == FS_RUN) begin
            if (can_load) begin
              if (end_hit) begin
                state_q <= FS_DRAIN;
              end else begin
                instr_q <= imem_instr;
                opc_q   <= pc_q;
                vld_q   <= 1'b1;
                pc_q    <= pc_q + PC_INC;
              end
            end
          end else if (!vld_q) begin
            state_q <= FS_DONE;
            done_q  <= 1'b1;
          end
        end
        FS_DONE: state_q <= FS_IDLE;
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  assign imem_pc     = pc_q;
  assign out_valid   = vld_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign busy        = (state_q != FS_IDLE);
  assign done        = done_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, redirect_valid, out_ready;
  logic [31:0] start_pc, redirect_pc, imem_pc, imem_instr, out_instr, out_pc;
  logic        out_valid, busy, done;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .busy(busy), .done(done), .fetch_count(fetch_count)
  );

  logic [31:0] rom [16];
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rom[0] = 32'h5100_0201; rom[1] = 32'h6110_0403; rom[2] = 32'h5200_0605;
    rom[3] = 32'h6220_0807; rom[4] = 32'h8312_0000; rom[5] = 32'h0430_0000;
    rom[6] = 32'h4512_0000;
  end
  assign imem_instr = (imem_pc < 32'd64) ? rom[imem_pc[5:2]] : 32'h0;

  int n_cmp = 0, n_bad = 0;
  int cyc_n = 0, last_hs = -100, done_at = -100;
  bit done_seen;
  logic [63:0] sb [$];   // {pc, instr}

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor at negedge (handshake about to happen at next posedge), then
  // return #1 after the posedge so the caller can drive inputs.
  task automatic cyc();
    logic [63:0] e;
    @(negedge clk);
    cyc_n++;
    if (out_valid && out_ready) begin
      last_hs = cyc_n;
      if (sb.size() == 0) chk("sb_extra", {out_pc, out_instr}, 64'h0);
      else begin
        e = sb.pop_front();
        chk("sb_word", {out_pc, out_instr}, e);
      end
    end
    if (done) begin done_seen = 1'b1; done_at = cyc_n; end
    @(posedge clk); #1;
  endtask

  task automatic push_seq(input int first, input int last);
    for (int i = first; i <= last; i++) sb.push_back({32'(i * 4), rom[i]});
  endtask

  task automatic run_to_done(input int bound);
    int k = 0;
    while (!done_seen && k < bound) begin cyc(); k++; end
    start = 1'b0;
    if (!done_seen) chk("done_timeout", 64'd0, 64'd1);
    cyc();
  endtask

  task automatic do_start(input logic [31:0] spc);
    done_seen = 1'b0;
    start = 1'b1; start_pc = spc;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_pc = '0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b0;
    @(posedge clk); #1; cyc();
    rst = 1'b0;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_pc", imem_pc, 32'h0);
    chk("rst_cnt", fetch_count, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // Normal run
    out_ready = 1'b1;
    push_seq(0, 6);
    do_start(32'h0);
    chk("lat_valid0", out_valid, 1'b0);
    cyc();
    chk("lat_valid1", out_valid, 1'b1);
    chk("lat_pc", out_pc, 32'h0);
    run_to_done(40);
    chk("norm_done_dly", 64'(done_at - last_hs), 64'd2);
    chk("norm_cnt", fetch_count, 16'd7);
    chk("norm_busy", busy, 1'b0);
    chk("norm_sb_left", sb.size(), 0);

    // Backpressure after first word
    out_ready = 1'b0;
    push_seq(0, 6);
    do_start(32'h0);
    for (int k = 0; k < 10 && !out_valid; k++) cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_instr", out_instr, 32'h5100_0201);
      chk("bp_imem_pc", imem_pc, 32'h4);
    end
    out_ready = 1'b1;
    run_to_done(40);
    chk("bp_cnt", fetch_count, 16'd7);
    chk("bp_sb_left", sb.size(), 0);

    // Redirect while 0x08 is buffered and stalled
    out_ready = 1'b1;
    push_seq(0, 1); push_seq(4, 6);
    do_start(32'h0);
    for (int k = 0; k < 10 && !(out_valid && out_pc == 32'h8); k++) cyc();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10;
    cyc();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("redir_valid", out_valid, 1'b0);
    chk("redir_pc", imem_pc, 32'h10);
    run_to_done(40);
    chk("redir_cnt", fetch_count, 16'd5);
    chk("redir_sb_left", sb.size(), 0);

    // Unaligned start near end of program
    push_seq(6, 6);
    do_start(32'h1A);
    run_to_done(40);
    chk("una_cnt", fetch_count, 16'd1);
    chk("una_sb_left", sb.size(), 0);

    // start held while busy (start_pc changed to prove it is not re-sampled)
    push_seq(0, 6);
    do_start(32'h0);
    start = 1'b1; start_pc = 32'h18;
    run_to_done(40);
    chk("sbusy_cnt", fetch_count, 16'd7);
    chk("sbusy_sb_left", sb.size(), 0);
    chk("sbusy_idle", busy, 1'b0);

    // Reset mid-run
    push_seq(0, 6);
    do_start(32'h0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    done_seen = 1'b0;
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_pc", imem_pc, 32'h0);
    chk("mrst_cnt", fetch_count, 16'h0);
    chk("mrst_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) cyc();
    chk("mrst_no_done", done_seen, 1'b0);
    chk("mrst_stay_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
